// File: rtl/du_word_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : du_word_stream_tx
// Description : Debug-unit transmitter that sends an optional PC header and a
//               block of source words to the UART Tx path, one byte at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module du_word_stream_tx #(
  parameter int NB_PC        = 32,
  parameter int NB_WORD      = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_UART_DATA = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_send_pc,
  input  logic                    i_msb_first,
  input  logic [NB_PC-1:0]        i_pc,
  input  logic [NB_ADDR-1:0]      i_base_addr,
  input  logic [NB_ADDR:0]        i_count,
  input  logic [NB_WORD-1:0]      i_rd_data,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_tx_start,
  output logic                    o_wr,
  output logic [NB_UART_DATA-1:0] o_wdata,
  output logic                    o_rd,
  output logic [NB_ADDR-1:0]      o_raddr
);

  localparam int C_BPW    = NB_WORD / NB_UART_DATA;
  localparam int C_BPP    = NB_PC / NB_UART_DATA;
  localparam int C_MAXB   = (C_BPW > C_BPP) ? C_BPW : C_BPP;
  localparam int C_BIDX_W = $clog2(C_MAXB + 1);
  localparam int C_LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int C_CNT_W  = NB_ADDR + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_TX    = 3'd1,
    ST_HDR_WAIT  = 3'd2,
    ST_RD_REQ    = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_WORD_TX   = 3'd5,
    ST_WORD_WAIT = 3'd6,
    ST_FINISH    = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NB_PC-1:0]      r_pc;
  logic [NB_WORD-1:0]    r_word;
  logic [NB_ADDR-1:0]    r_addr;
  logic [C_CNT_W-1:0]    r_remaining;
  logic                  r_msb_first;
  logic [C_BIDX_W-1:0]   r_byte_idx;
  logic [C_LAT_W-1:0]    r_lat;

  logic                    w_hdr_last;
  logic                    w_word_last;
  logic                    w_lat_last;
  logic                    w_more_words;
  logic                    w_more_after;
  logic [C_BIDX_W-1:0]     w_hdr_sel;
  logic [C_BIDX_W-1:0]     w_word_sel;
  logic [NB_UART_DATA-1:0] w_hdr_byte;
  logic [NB_UART_DATA-1:0] w_word_byte;

  assign w_hdr_last   = (r_byte_idx == C_BIDX_W'(C_BPP - 1));
  assign w_word_last  = (r_byte_idx == C_BIDX_W'(C_BPW - 1));
  assign w_lat_last   = (r_lat == C_LAT_W'(RD_LATENCY - 1));
  assign w_more_words = (r_remaining != '0);
  assign w_more_after = (r_remaining > C_CNT_W'(1));

  // Byte index always counts upward; MSB-first mirrors it onto the word.
  assign w_hdr_sel  = r_msb_first ? (C_BIDX_W'(C_BPP - 1) - r_byte_idx) : r_byte_idx;
  assign w_word_sel = r_msb_first ? (C_BIDX_W'(C_BPW - 1) - r_byte_idx) : r_byte_idx;

  always_comb begin
    w_hdr_byte  = '0;
    w_word_byte = '0;
    for (int k = 0; k < C_BPP; k++) begin
      if (w_hdr_sel == C_BIDX_W'(k)) w_hdr_byte = r_pc[k*NB_UART_DATA +: NB_UART_DATA];
    end
    for (int k = 0; k < C_BPW; k++) begin
      if (w_word_sel == C_BIDX_W'(k)) w_word_byte = r_word[k*NB_UART_DATA +: NB_UART_DATA];
    end
  end

  always_comb begin
    w_next     = r_state;
    o_busy     = (r_state != ST_IDLE);
    o_done     = 1'b0;
    o_tx_start = 1'b0;
    o_wr       = 1'b0;
    o_wdata    = '0;
    o_rd       = 1'b0;
    o_raddr    = r_addr;

    if (i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_send_pc)            w_next = ST_HDR_TX;
            else if (i_count != '0)   w_next = ST_RD_REQ;
            else                      w_next = ST_FINISH;
          end
        end
        ST_HDR_TX: begin
          o_wr       = 1'b1;
          o_tx_start = 1'b1;
          o_wdata    = w_hdr_byte;
          w_next     = ST_HDR_WAIT;
        end
        ST_HDR_WAIT: begin
          if (i_tx_done) begin
            if (!w_hdr_last)        w_next = ST_HDR_TX;
            else if (w_more_words)  w_next = ST_RD_REQ;
            else                    w_next = ST_FINISH;
          end
        end
        ST_RD_REQ: begin
          o_rd   = 1'b1;
          w_next = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_lat_last) w_next = ST_WORD_TX;
        end
        ST_WORD_TX: begin
          o_wr       = 1'b1;
          o_tx_start = 1'b1;
          o_wdata    = w_word_byte;
          w_next     = ST_WORD_WAIT;
        end
        ST_WORD_WAIT: begin
          if (i_tx_done) begin
            if (!w_word_last)       w_next = ST_WORD_TX;
            else if (w_more_after)  w_next = ST_RD_REQ;
            else                    w_next = ST_FINISH;
          end
        end
        ST_FINISH: begin
          o_done = 1'b1;
          w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_word      <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_msb_first <= 1'b0;
      r_byte_idx  <= '0;
      r_lat       <= '0;
    end else begin
      r_state <= w_next;
      if (!i_abort) begin
        case (r_state)
          ST_IDLE: begin
            r_byte_idx <= '0;
            r_lat      <= '0;
            if (i_start) begin
              r_pc        <= i_pc;
              r_addr      <= i_base_addr;
              r_remaining <= i_count;
              r_msb_first <= i_msb_first;
            end
          end
          ST_HDR_WAIT: begin
            if (i_tx_done) r_byte_idx <= w_hdr_last ? '0 : r_byte_idx + C_BIDX_W'(1);
          end
          ST_RD_WAIT: begin
            if (w_lat_last) begin
              r_word <= i_rd_data;
              r_lat  <= '0;
            end else begin
              r_lat  <= r_lat + C_LAT_W'(1);
            end
          end
          ST_WORD_WAIT: begin
            if (i_tx_done) begin
              if (w_word_last) begin
                r_byte_idx  <= '0;
                r_remaining <= r_remaining - C_CNT_W'(1);
                r_addr      <= r_addr + NB_ADDR'(1);
              end else begin
                r_byte_idx  <= r_byte_idx + C_BIDX_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_du_word_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_du_word_stream_tx
// Description : Directed self-checking bench for du_word_stream_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_du_word_stream_tx;

  logic        clk;
  logic        rst_n, start1, start3, abort, send_pc, msb_first;
  logic [31:0] pc;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic [31:0] rd_data1, rd_data3;
  logic        tx_done1, tx_done3;
  logic        busy1, done1, txs1, wr1, rd1;
  logic        busy3, done3, txs3, wr3, rd3;
  logic [7:0]  wdata1, wdata3;
  logic [4:0]  raddr1, raddr3;

  du_word_stream_tx #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort),
    .i_send_pc(send_pc), .i_msb_first(msb_first), .i_pc(pc),
    .i_base_addr(base_addr), .i_count(count), .i_rd_data(rd_data1),
    .i_tx_done(tx_done1), .o_busy(busy1), .o_done(done1), .o_tx_start(txs1),
    .o_wr(wr1), .o_wdata(wdata1), .o_rd(rd1), .o_raddr(raddr1)
  );

  du_word_stream_tx #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort),
    .i_send_pc(send_pc), .i_msb_first(msb_first), .i_pc(pc),
    .i_base_addr(base_addr), .i_count(count), .i_rd_data(rd_data3),
    .i_tx_done(tx_done3), .o_busy(busy3), .o_done(done3), .o_tx_start(txs3),
    .o_wr(wr3), .o_wdata(wdata3), .o_rd(rd3), .o_raddr(raddr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read source memory with 1- and 3-cycle pipelines.
  logic [31:0] mem [32];
  logic [31:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    rd_data1 <= mem[raddr1];
    p3a      <= mem[raddr3];
    p3b      <= p3a;
    p3c      <= p3b;
  end
  assign rd_data3 = p3c;

  // UART responder: tx_done for rsp_wid cycles starting rsp_dly cycles after
  // the cycle following o_wr; optionally also asserted during o_wr itself.
  int   rsp_dly = 1, rsp_wid = 1;
  logic rsp_coin = 1'b0;
  int   rcnt1 = 0, rcnt3 = 0;
  always @(negedge clk) begin
    if (wr1) begin
      rcnt1 = rsp_dly + rsp_wid; tx_done1 = rsp_coin;
    end else begin
      tx_done1 = (rcnt1 > 0) && (rcnt1 <= rsp_wid);
      if (rcnt1 > 0) rcnt1--;
    end
    if (wr3) begin
      rcnt3 = rsp_dly + rsp_wid; tx_done3 = rsp_coin;
    end else begin
      tx_done3 = (rcnt3 > 0) && (rcnt3 <= rsp_wid);
      if (rcnt3 > 0) rcnt3--;
    end
  end

  // Output monitors.
  logic [7:0] wr1_q[$], wr3_q[$];
  logic [4:0] rd1_q[$], rd3_q[$];
  int rd3_cyc_q[$], wr3_cyc_q[$];
  int done1_cnt = 0, done3_cnt = 0, done1_cyc = 0, bad_cnt = 0;
  always @(negedge clk) begin
    if (wr1) wr1_q.push_back(wdata1);
    if (rd1) rd1_q.push_back(raddr1);
    if (done1) begin done1_cnt++; done1_cyc = cyc; end
    if (wr3) begin wr3_q.push_back(wdata3); wr3_cyc_q.push_back(cyc); end
    if (rd3) begin rd3_q.push_back(raddr3); rd3_cyc_q.push_back(cyc); end
    if (done3) done3_cnt++;
    if ((!wr1 && wdata1 != 8'h00) || (txs1 != wr1)) bad_cnt++;
    if ((!wr3 && wdata3 != 8'h00) || (txs3 != wr3)) bad_cnt++;
  end

  int checks = 0, errors = 0;
  int s_cyc;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int base);
    int got, mism;
    got  = wr1_q.size() - base;
    mism = 0;
    check({tag, "_nbytes"}, 64'(got), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (wr1_q[base+i] !== exp_q[i]) mism++;
    check({tag, "_bad_bytes"}, 64'(mism), 64'd0);
  endtask

  task automatic push_word(input logic [31:0] w, input logic msb);
    for (int i = 0; i < 4; i++) begin
      if (msb) exp_q.push_back(w[(3-i)*8 +: 8]);
      else     exp_q.push_back(w[i*8 +: 8]);
    end
  endtask

  task automatic go(input logic use3, input logic sp, input logic msb,
                    input logic [31:0] p, input logic [4:0] b, input logic [5:0] n);
    @(posedge clk); #1;
    send_pc = sp; msb_first = msb; pc = p; base_addr = b; count = n;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    pc = 32'h5A5A5A5A; base_addr = 5'h15; count = 6'd9;
    send_pc = ~sp; msb_first = ~msb;
  endtask

  task automatic wait_done(input logic use3, input string tag, input int target, input int budget);
    int n = 0;
    while (((use3 ? done3_cnt : done1_cnt) < target) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_done_seen"}, 64'((use3 ? done3_cnt : done1_cnt) >= target), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int wb, rb, dc, mism;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; abort = 1'b0;
    send_pc = 1'b0; msb_first = 1'b0; pc = '0; base_addr = '0; count = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h01010101;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy1, done1, txs1, wr1, wdata1, rd1, raddr1}, 64'd0);
    rst_n = 1'b1;

    // Full register-file dump with PC header, LSB first.
    wb = wr1_q.size(); rb = rd1_q.size(); dc = done1_cnt;
    go(1'b0, 1'b1, 1'b0, 32'h00001234, 5'd0, 6'd32);
    wait_done(1'b0, "dump", dc + 1, 2000);
    exp_q.delete();
    push_word(32'h00001234, 1'b0);
    for (int i = 0; i < 32; i++) push_word(32'(i) * 32'h01010101, 1'b0);
    check_bytes("dump", wb);
    mism = 0;
    for (int i = 0; i < 32 && rb + i < rd1_q.size(); i++) if (rd1_q[rb+i] !== 5'(i)) mism++;
    check("dump_nreads", 64'(rd1_q.size() - rb), 64'd32);
    check("dump_raddr_bad", 64'(mism), 64'd0);
    check("dump_ndone", 64'(done1_cnt - dc), 64'd1);
    check("dump_idle", {63'd0, busy1}, 64'd0);

    // MSB first with a 3-cycle read latency.
    mem[7] = 32'hAABBCCDD;
    go(1'b1, 1'b0, 1'b1, 32'h0, 5'd7, 6'd1);
    wait_done(1'b1, "lat3", 1, 200);
    check("lat3_rd_cycle", 64'(rd3_cyc_q[0] - s_cyc), 64'd1);
    check("lat3_wr_cycle", 64'(wr3_cyc_q[0] - s_cyc), 64'd5);
    check("lat3_raddr", 64'(rd3_q[0]), 64'd7);
    check("lat3_nbytes", 64'(wr3_q.size()), 64'd4);
    check("lat3_bytes", {wr3_q[0], wr3_q[1], wr3_q[2], wr3_q[3]}, 64'hAABBCCDD);

    // Address wrap.
    wb = wr1_q.size(); rb = rd1_q.size();
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd30, 6'd4);
    wait_done(1'b0, "wrap", done1_cnt + 1, 500);
    check("wrap_raddrs", {rd1_q[rb], rd1_q[rb+1], rd1_q[rb+2], rd1_q[rb+3]},
          {5'd30, 5'd31, 5'd0, 5'd1});
    check("wrap_nbytes", 64'(wr1_q.size() - wb), 64'd16);

    // Zero count, no header.
    wb = wr1_q.size(); dc = done1_cnt;
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 6'd0);
    wait_done(1'b0, "zero", dc + 1, 50);
    check("zero_done_cycle", 64'(done1_cyc - s_cyc), 64'd1);
    check("zero_nbytes", 64'(wr1_q.size() - wb), 64'd0);

    // Zero count with header.
    wb = wr1_q.size(); rb = rd1_q.size();
    go(1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 5'd3, 6'd0);
    wait_done(1'b0, "hdronly", done1_cnt + 1, 100);
    exp_q.delete(); push_word(32'hCAFEF00D, 1'b0);
    check_bytes("hdronly", wb);
    check("hdronly_nreads", 64'(rd1_q.size() - rb), 64'd0);

    // Wide tx_done pulses plus tx_done coinciding with o_wr.
    rsp_dly = 0; rsp_wid = 3; rsp_coin = 1'b1;
    wb = wr1_q.size();
    go(1'b0, 1'b1, 1'b1, 32'h11223344, 5'd2, 6'd2);
    wait_done(1'b0, "hshk", done1_cnt + 1, 300);
    exp_q.delete();
    push_word(32'h11223344, 1'b1); push_word(mem[2], 1'b1); push_word(mem[3], 1'b1);
    check_bytes("hshk", wb);
    rsp_dly = 1; rsp_wid = 1; rsp_coin = 1'b0;

    // i_start while busy is ignored.
    wb = wr1_q.size(); rb = rd1_q.size(); dc = done1_cnt;
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd4, 6'd3);
    for (int n = 0; n < 200 && rd1_q.size() - rb < 2; n++) begin @(posedge clk); #1; end
    send_pc = 1'b1; base_addr = 5'd20; count = 6'd1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done(1'b0, "busystart", dc + 1, 300);
    exp_q.delete();
    for (int i = 4; i < 7; i++) push_word(mem[i], 1'b0);
    check_bytes("busystart", wb);
    check("busystart_ndone", 64'(done1_cnt - dc), 64'd1);

    // Abort in the wait after the second byte.
    wb = wr1_q.size(); dc = done1_cnt;
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd9, 6'd2);
    for (int n = 0; n < 200 && wr1_q.size() - wb < 2; n++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy", {63'd0, busy1}, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_nbytes", 64'(wr1_q.size() - wb), 64'd2);
    check("abort_ndone", 64'(done1_cnt - dc), 64'd0);

    // Abort wins over start in IDLE.
    @(posedge clk); #1;
    count = 6'd1; start1 = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort = 1'b0;
    check("abort_start_idle", {63'd0, busy1}, 64'd0);

    // Clean restart after abort.
    wb = wr1_q.size(); rb = rd1_q.size();
    go(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd12, 6'd1);
    wait_done(1'b0, "restart", done1_cnt + 1, 200);
    exp_q.delete(); push_word(32'hDEADBEEF, 1'b1); push_word(mem[12], 1'b1);
    check_bytes("restart", wb);
    check("restart_raddr", 64'(rd1_q[rb]), 64'd12);

    // Reset during RD_WAIT.
    wb = wr1_q.size(); rb = rd1_q.size(); dc = done1_cnt;
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 6'd2);
    for (int n = 0; n < 50 && rd1_q.size() - rb < 1; n++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("rst_mid_outputs", {busy1, done1, txs1, wr1, wdata1, rd1, raddr1}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_ndone", 64'(done1_cnt - dc), 64'd0);
    check("rst_mid_nbytes", 64'(wr1_q.size() - wb), 64'd0);
    wb = wr1_q.size();
    go(1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 6'd1);
    wait_done(1'b0, "rst_restart", done1_cnt + 1, 100);
    exp_q.delete(); push_word(mem[5], 1'b0);
    check_bytes("rst_restart", wb);

    check("wdata_idle_and_txstart", 64'(bad_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
